// File: rtl/clkdiv_axil_if.sv
// AXI4-Lite bus bundle for the clock-divider register block.
// The slave modport is the register-block view; the master modport is the CPU/bench view.
interface clkdiv_axil_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/clkdiv_axil_regs.sv
// AXI4-Lite register block driving clock_divider: staged divisor with atomic APPLY and divider reset.
// Optional feature macro CLKDIV_EDGE_CNT_EN adds the EDGE_CNT register at 0x10.
module clkdiv_axil_regs #(
    parameter int               ADDR_W    = 5,
    parameter int               DIV_W     = 33,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(1)
) (
    input  logic             clk_in,
    input  logic             reset,
    clkdiv_axil_if.slave     s,
    output logic [DIV_W-1:0] clk_div,
    output logic             div_reset_n,
    input  logic             clk_fb
);
    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] ADDR_DIV_LO = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] ADDR_DIV_HI = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8'h0C);
`ifdef CLKDIV_EDGE_CNT_EN
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = ADDR_W'(8'h10);
`endif

    w_state_t          w_state;
    r_state_t          r_state;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              en, en_nxt, apply_now, wr_commit;
    logic [DIV_W-1:0]  staging, staging_nxt, active;
    logic [63:0]       staging_ext;
    logic [31:0]       rd_word;
    logic              aw_hs, w_hs;

    function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
        case (addr)
            ADDR_CTRL, ADDR_DIV_LO, ADDR_DIV_HI, ADDR_STATUS: is_mapped = 1'b1;
`ifdef CLKDIV_EDGE_CNT_EN
            ADDR_EDGE: is_mapped = 1'b1;
`endif
            default: is_mapped = 1'b0;
        endcase
    endfunction

    assign clk_div     = active;
    assign staging_ext = 64'(staging);
    assign aw_hs       = s.s_awvalid && s.s_awready;
    assign w_hs        = s.s_wvalid && s.s_wready;
    assign wr_commit   = (w_state == W_IDLE) && aw_held && w_held;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        en_nxt      = en;
        apply_now   = 1'b0;
        staging_nxt = staging;
        if (wr_commit && wr_addr == ADDR_CTRL && wstrb_q[0]) begin
            en_nxt    = wdata_q[0];
            apply_now = wdata_q[1];
        end
        // Bits below 32 live in DIV_LO, the rest in DIV_HI; each byte gated by its strobe.
        for (int i = 0; i < DIV_W; i++) begin
            if (wr_commit && wr_addr == ((i < 32) ? ADDR_DIV_LO : ADDR_DIV_HI)
                && wstrb_q[(i % 32) / 8])
                staging_nxt[i] = wdata_q[i % 32];
        end
    end

`ifdef CLKDIV_EDGE_CNT_EN
    logic        clk_fb_d1;
    logic [31:0] edge_cnt;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            clk_fb_d1 <= 1'b0;
            edge_cnt  <= '0;
        end else begin
            clk_fb_d1 <= clk_fb;
            if (apply_now || (wr_commit && wr_addr == ADDR_EDGE))
                edge_cnt <= '0;
            else if (div_reset_n && clk_fb && !clk_fb_d1)
                edge_cnt <= edge_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (s.s_araddr)
            ADDR_CTRL:   rd_word = {31'd0, en};
            ADDR_DIV_LO: rd_word = staging_ext[31:0];
            ADDR_DIV_HI: rd_word = staging_ext[63:32];
            ADDR_STATUS: rd_word = {30'd0, staging != active, clk_fb};
`ifdef CLKDIV_EDGE_CNT_EN
            ADDR_EDGE:   rd_word = edge_cnt;
`endif
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            wr_addr     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s.s_awready <= 1'b0;
            s.s_wready  <= 1'b0;
            s.s_bvalid  <= 1'b0;
            s.s_bresp   <= RESP_OKAY;
            en          <= 1'b0;
            staging     <= DIV_RESET;
            active      <= DIV_RESET;
            div_reset_n <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            en          <= en_nxt;
            staging     <= staging_nxt;
            div_reset_n <= en_nxt && !apply_now;
            if (apply_now)
                active <= staging;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_addr <= s.s_awaddr;
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= s.s_wdata;
                        wstrb_q <= s.s_wstrb;
                        w_held  <= 1'b1;
                    end
                    s.s_awready <= !(aw_held || aw_hs);
                    s.s_wready  <= !(w_held || w_hs);
                    if (wr_commit) begin
                        s.s_bvalid <= 1'b1;
                        s.s_bresp  <= is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s.s_bready) begin
                        s.s_bvalid  <= 1'b0;
                        aw_held     <= 1'b0;
                        w_held      <= 1'b0;
                        s.s_awready <= 1'b1;
                        s.s_wready  <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // rdata is captured on the AR handshake, so a same-cycle write commit is not yet visible.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= R_IDLE;
            s.s_arready <= 1'b0;
            s.s_rvalid  <= 1'b0;
            s.s_rdata   <= '0;
            s.s_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s.s_arready <= 1'b1;
                    if (s.s_arvalid && s.s_arready) begin
                        s.s_arready <= 1'b0;
                        s.s_rvalid  <= 1'b1;
                        s.s_rdata   <= rd_word;
                        s.s_rresp   <= is_mapped(s.s_araddr) ? RESP_OKAY : RESP_SLVERR;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s.s_rready) begin
                        s.s_rvalid  <= 1'b0;
                        s.s_arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clkdiv_axil_regs.sv
// Directed bench for clkdiv_axil_regs; the 0x10 checks follow CLKDIV_EDGE_CNT_EN like the RTL.
module tb_clkdiv_axil_regs;
    localparam int ADDR_W = 5;
    localparam int DIV_W  = 33;

    logic             clk_in = 1'b0;
    logic             reset  = 1'b1;
    logic             clk_fb = 1'b0;
    logic [DIV_W-1:0] clk_div;
    logic             div_reset_n;

    int               errors  = 0;
    int               checks  = 0;
    int               low_cnt = 0;
    logic [DIV_W-1:0] snap_div;
    logic             snap_rstn;

    clkdiv_axil_if #(.ADDR_W(ADDR_W)) bus ();

    clkdiv_axil_regs #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .DIV_RESET(33'd1)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .s           (bus),
        .clk_div     (clk_div),
        .div_reset_n (div_reset_n),
        .clk_fb      (clk_fb)
    );

    always #5 clk_in = ~clk_in;

    // Counts clock periods in which the divider is held in reset.
    always @(negedge clk_in) if (div_reset_n === 1'b0) low_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_aw(input logic [ADDR_W-1:0] addr);
        bit done = 1'b0;
        bus.s_awaddr  = addr;
        bus.s_awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.s_awready;
            tick();
        end
        bus.s_awvalid = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL aw_timeout: awready=0 for 50 cycles, required 1 (addr %h)", addr);
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit done = 1'b0;
        bus.s_wdata  = data;
        bus.s_wstrb  = strb;
        bus.s_wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.s_wready;
            tick();
        end
        bus.s_wvalid = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL w_timeout: wready=0 for 50 cycles, required 1");
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit done = 1'b0;
        resp = 2'bxx;
        bus.s_bready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_bvalid) begin
                done      = 1'b1;
                resp      = bus.s_bresp;
                snap_div  = clk_div;
                snap_rstn = div_reset_n;
            end
            tick();
        end
        bus.s_bready = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL b_timeout: bvalid=0 for 50 cycles, required 1");
        end
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        send_aw(addr);
        send_w(data, strb);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done = 1'b0;
        data = 'x;
        resp = 2'bxx;
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.s_arready;
            tick();
        end
        bus.s_arvalid = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL ar_timeout: arready=0 for 50 cycles, required 1 (addr %h)", addr);
        end
        done = 1'b0;
        bus.s_rready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.s_rvalid) begin
                done = 1'b1;
                data = bus.s_rdata;
                resp = bus.s_rresp;
            end
            tick();
        end
        bus.s_rready = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL r_timeout: rvalid=0 for 50 cycles, required 1 (addr %h)", addr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0 || bus.s_arready !== 1'b0 ||
            bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 || bus.s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_handshake: aw/w/ar ready=%b%b%b bvalid=%b rvalid=%b rdata=%h, required all 0",
                     bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid, bus.s_rdata);
        end
        checks++;
        if (clk_div !== 33'd1 || div_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_div: clk_div=%h div_reset_n=%b, required 1 / 0", clk_div, div_reset_n);
        end
        reset = 1'b0;
        tick();
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl: data=%h resp=%b, required 0 / 00", d, r);
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin
            errors++; $display("FAIL reset_div_lo: data=%h resp=%b, required 1 / 00", d, r);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL reset_status: data=%h resp=%b, required 0 / 00", d, r);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        logic [1:0]  r;
        send_w(32'h10, 4'hF);
        repeat (2) tick();
        send_aw(5'h04);
        wait_b(r);
        checks++;
        if (r !== 2'b00 || bus.s_bvalid !== 1'b0) begin
            errors++; $display("FAIL split_bresp: resp=%b bvalid_after=%b, required 00 / 0", r, bus.s_bvalid);
        end
        checks++;
        if (clk_div !== 33'd1) begin
            errors++; $display("FAIL split_clk_div: clk_div=%h, required 1 (staging only)", clk_div);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL split_pending: status=%h, required 2", d);
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h10) begin
            errors++; $display("FAIL split_div_lo: data=%h, required 10", d);
        end
    endtask

    task automatic test_apply();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h00, 32'h3, 4'hF, r);
        checks++;
        if (r !== 2'b00 || snap_div !== 33'h10 || snap_rstn !== 1'b0) begin
            errors++;
            $display("FAIL apply_commit: resp=%b clk_div=%h div_reset_n=%b, required 00 / 10 / 0",
                     r, snap_div, snap_rstn);
        end
        checks++;
        if (div_reset_n !== 1'b1 || clk_div !== 33'h10) begin
            errors++; $display("FAIL apply_after: div_reset_n=%b clk_div=%h, required 1 / 10", div_reset_n, clk_div);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL apply_status: status=%h, required 0", d);
        end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL apply_ctrl_read: ctrl=%h, required 1 (APPLY reads 0)", d);
        end
    endtask

    task automatic test_div_hi_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'hDEADBE55, 4'h2, r);
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h0000BE10) begin
            errors++; $display("FAIL lo_strobe: data=%h, required 0000be10", d);
        end
        axi_write(5'h04, 32'h00000010, 4'h3, r);
        axi_write(5'h08, 32'h1, 4'h0, r);
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL hi_nostrobe: data=%h resp=%b, required 0 / 00", d, r);
        end
        axi_write(5'h08, 32'hFFFFFFFF, 4'hF, r);
        axi_read(5'h08, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL hi_unused_bits: data=%h, required 1", d);
        end
        low_cnt = 0;
        axi_write(5'h00, 32'h3, 4'h2, r);
        checks++;
        if (clk_div !== 33'h10 || div_reset_n !== 1'b1 || low_cnt !== 0) begin
            errors++;
            $display("FAIL apply_no_strb0: clk_div=%h div_reset_n=%b low=%0d, required 10 / 1 / 0",
                     clk_div, div_reset_n, low_cnt);
        end
        low_cnt = 0;
        axi_write(5'h00, 32'h3, 4'h1, r);
        checks++;
        if (clk_div !== 33'h1_0000_0010 || div_reset_n !== 1'b1 || low_cnt !== 1) begin
            errors++;
            $display("FAIL apply_hi: clk_div=%h div_reset_n=%b low=%0d, required 100000010 / 1 / 1",
                     clk_div, div_reset_n, low_cnt);
        end
    endtask

    task automatic test_en_off();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h00, 32'h0, 4'hF, r);
        checks++;
        if (snap_rstn !== 1'b0 || div_reset_n !== 1'b0 || clk_div !== 33'h1_0000_0010) begin
            errors++;
            $display("FAIL en_off: rstn_at_b=%b rstn=%b clk_div=%h, required 0 / 0 / 100000010",
                     snap_rstn, div_reset_n, clk_div);
        end
        axi_write(5'h04, 32'h0, 4'hF, r);
        axi_write(5'h08, 32'h0, 4'hF, r);
        axi_write(5'h00, 32'h2, 4'hF, r);
        checks++;
        if (clk_div !== 33'h0 || div_reset_n !== 1'b0) begin
            errors++; $display("FAIL apply_en0: clk_div=%h div_reset_n=%b, required 0 / 0", clk_div, div_reset_n);
        end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL en0_ctrl: ctrl=%h, required 0", d);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  br;
        send_aw(5'h04);
        send_w(32'h5A, 4'hF);
        axi_read(5'h04, d, r);
        wait_b(br);
        checks++;
        if (d !== 32'h0 || br !== 2'b00) begin
            errors++; $display("FAIL same_cycle_read: data=%h bresp=%b, required 0 / 00", d, br);
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h5A) begin
            errors++; $display("FAIL same_cycle_after: data=%h, required 5a", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        bit          seen = 1'b0;
        send_aw(5'h14);
        send_w(32'hFFFF, 4'hF);
        bus.s_bready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = bus.s_bvalid;
            if (!seen) tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL slverr_bvalid: bvalid=0 for 20 cycles, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b10 || bus.s_awready !== 1'b0) begin
                errors++;
                $display("FAIL bstall_%0d: bvalid=%b bresp=%b awready=%b, required 1 / 10 / 0",
                         i, bus.s_bvalid, bus.s_bresp, bus.s_awready);
            end
        end
        wait_b(r);
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL slverr_read: data=%h resp=%b, required 0 / 10", d, r);
        end
        axi_write(5'h0C, 32'hFFFFFFFF, 4'hF, r);
        axi_read(5'h00, d, r);
        checks++;
        if (r !== 2'b00 || d !== 32'h0) begin
            errors++; $display("FAIL status_write: ctrl=%h resp=%b, required 0 / 00", d, r);
        end
        clk_fb = 1'b1;
        axi_read(5'h0C, d, r);
        clk_fb = 1'b0;
        checks++;
        if (d !== 32'h3) begin
            errors++; $display("FAIL status_fb: status=%h, required 3", d);
        end
    endtask

    task automatic test_edge_cnt();
        logic [31:0] d;
        logic [1:0]  r;
`ifdef CLKDIV_EDGE_CNT_EN
        axi_write(5'h04, 32'h2, 4'hF, r);
        axi_write(5'h00, 32'h3, 4'hF, r);
        axi_write(5'h10, 32'h0, 4'hF, r);
        for (int i = 0; i < 60; i++) begin
            clk_fb = ((i % 6) < 3);
            tick();
        end
        clk_fb = 1'b0;
        axi_read(5'h10, d, r);
        checks++;
        if (d < 32'd9 || d > 32'd11 || r !== 2'b00) begin
            errors++; $display("FAIL edge_cnt: count=%0d resp=%b, required 10+-1 / 00", d, r);
        end
        axi_write(5'h10, 32'h0, 4'hF, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL edge_clear: count=%h resp=%b, required 0 / 00", d, r);
        end
`else
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL edge_unmapped_rd: data=%h resp=%b, required 0 / 10", d, r);
        end
        axi_write(5'h10, 32'h0, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            errors++; $display("FAIL edge_unmapped_wr: resp=%b, required 10", r);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        logic [1:0]  r;
        bit          bad = 1'b0;
        send_aw(5'h04);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_w(32'h77, 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (bus.s_bvalid !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL abort_no_resp: bvalid seen after aborted write, required none");
        end
        axi_read(5'h04, d, r);
        checks++;
        if (d !== 32'h1 || clk_div !== 33'd1) begin
            errors++; $display("FAIL abort_state: div_lo=%h clk_div=%h, required 1 / 1", d, clk_div);
        end
        send_aw(5'h0C);
        wait_b(r);
        axi_read(5'h04, d, r);
        checks++;
        if (r !== 2'b00 || d !== 32'h1) begin
            errors++; $display("FAIL abort_complete: div_lo=%h resp=%b, required 1 / 00", d, r);
        end
    endtask

    initial begin
        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        test_reset();
        test_split_write();
        test_apply();
        test_div_hi_strobes();
        test_en_off();
        test_same_cycle();
        test_errors();
        test_edge_cnt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
